i2s_master_tx: RTL

I2S_MASTER_TX -- requirements
Module: i2s_master_tx

---
 rtl/i2s_master_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: BCLK/LRCK generation, one-deep sample-pair buffer, MSB-first serialiser.
// Optional macro I2S_TX_UNDERRUN_EN: zero-fill underrun frames and expose sticky o_underrun.
module i2s_master_tx #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned CLK_DIV   = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_left,
   input  logic [DATA_W-1:0] i_right,
   output logic              o_ready,
   output logic              o_bclk,
   output logic              o_lrck,
   output logic              o_dat
`ifdef I2S_TX_UNDERRUN_EN
   ,
   output logic              o_underrun
`endif
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned      K_W      = $clog2(SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(SLOT_BITS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [K_W-1:0]    k_q, k_d, k_inc;
   logic              bclk_q, bclk_d;
   logic              lrck_q, lrck_d;
   logic              dat_q, dat_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
   logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
   logic              tick, fall, k_wrap, lr_inc, frame_start, stop, accept, data_slot;
`ifdef I2S_TX_UNDERRUN_EN
   logic              underrun_q, underrun_d;
`endif

   // Rotate rather than shift so a full slot leaves the word intact for replay.
   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
      return (v << 1) | (v >> (DATA_W - 1));
   endfunction

   assign tick        = (state_q == S_RUN) && (div_q == DIV_LAST);
   assign fall        = tick && bclk_q;
   assign k_wrap      = (k_q == K_LAST);
   assign k_inc       = k_wrap ? '0 : k_q + 1'b1;
   assign lr_inc      = k_wrap ? ~lrck_q : lrck_q;
   assign frame_start = fall && k_wrap && lrck_q;
   assign stop        = frame_start && !i_en;
   assign accept      = i_valid && ready_q;
   assign data_slot   = (k_inc != '0) && (32'(k_inc) <= DATA_W);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_en) state_d = S_RUN;
         S_RUN:   if (stop) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_d   = div_q;
      k_d     = k_q;
      bclk_d  = bclk_q;
      lrck_d  = lrck_q;
      dat_d   = dat_q;
      ready_d = ready_q;
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
      sh_l_d  = sh_l_q;
      sh_r_d  = sh_r_q;
`ifdef I2S_TX_UNDERRUN_EN
      underrun_d = underrun_q;
`endif
      if (state_q == S_IDLE) begin
         div_d  = '0;
         k_d    = K_LAST;
         bclk_d = 1'b0;
         lrck_d = 1'b1;
         dat_d  = 1'b0;
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) bclk_d = ~bclk_q;
         if (stop) begin
            k_d    = K_LAST;
            lrck_d = 1'b1;
            dat_d  = 1'b0;
         end else if (fall) begin
            k_d    = k_inc;
            lrck_d = lr_inc;
            dat_d  = 1'b0;
            if (frame_start) begin
               if (!ready_q) begin
                  sh_l_d  = buf_l_q;
                  sh_r_d  = buf_r_q;
                  ready_d = 1'b1;
               end
`ifdef I2S_TX_UNDERRUN_EN
               else begin
                  sh_l_d     = '0;
                  sh_r_d     = '0;
                  underrun_d = 1'b1;
               end
`endif
            end else if (data_slot) begin
               if (lr_inc) begin
                  dat_d  = sh_r_q[DATA_W-1];
                  sh_r_d = rotl(sh_r_q);
               end else begin
                  dat_d  = sh_l_q[DATA_W-1];
                  sh_l_d = rotl(sh_l_q);
               end
            end
         end
      end
      // Acceptance after the frame-start load: an underrun-cycle pair lands in the buffer only.
      if (accept) begin
         buf_l_d = i_left;
         buf_r_d = i_right;
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q   <= '0;
         k_q     <= K_LAST;
         bclk_q  <= 1'b0;
         lrck_q  <= 1'b1;
         dat_q   <= 1'b0;
         ready_q <= 1'b1;
         buf_l_q <= '0;
         buf_r_q <= '0;
         sh_l_q  <= '0;
         sh_r_q  <= '0;
`ifdef I2S_TX_UNDERRUN_EN
         underrun_q <= 1'b0;
`endif
      end else begin
         div_q   <= div_d;
         k_q     <= k_d;
         bclk_q  <= bclk_d;
         lrck_q  <= lrck_d;
         dat_q   <= dat_d;
         ready_q <= ready_d;
         buf_l_q <= buf_l_d;
         buf_r_q <= buf_r_d;
         sh_l_q  <= sh_l_d;
         sh_r_q  <= sh_r_d;
`ifdef I2S_TX_UNDERRUN_EN
         underrun_q <= underrun_d;
`endif
      end
   end

   assign o_ready = ready_q;
   assign o_bclk  = bclk_q;
   assign o_lrck  = lrck_q;
   assign o_dat   = dat_q;
`ifdef I2S_TX_UNDERRUN_EN
   assign o_underrun = underrun_q;
`endif

endmodule
